cpu_clken_gen: RTL and testbench

Generates the Z80 T-state clock enable from the 28 MHz master clock at the speed requested by the video/speed control register block. Consumes its `cpu_speed` output and applies it glitch-free: changes take effect only on a 3.5 MHz phase boundary, so ULA timing stays aligned. Also suppresses enables during wait/contention, forces 3.5 MHz on demand, and stretches the ULA frame interrupt to 32 CPU T-states at any speed.

---
 rtl/cpu_clken_gen_pkg.sv | 29 ++
 rtl/cpu_clken_gen_int_stretcher.sv | 59 +++++
 rtl/cpu_clken_gen.sv | 72 +++++++
 tb/tb_cpu_clken_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clken_gen_pkg.sv
// ============================================================================
// cpu_clken_gen_pkg -- speed codes, cpu_speed mapping and stretcher states
// Revision 1.0
// ============================================================================
`default_nettype none

package cpu_clken_gen_pkg;

  localparam logic [1:0] SPD_3M5 = 2'b00;
  localparam logic [1:0] SPD_7M  = 2'b01;
  localparam logic [1:0] SPD_14M = 2'b10;
  localparam logic [1:0] SPD_28M = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ASSERT = 1'b1
  } int_st_t;

  // Codes above 2 all saturate to full master-clock speed.
  function automatic logic [1:0] speed_code(input logic [3:0] cs);
    if (cs >= 4'd3) begin
      return SPD_28M;
    end
    return cs[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_clken_gen_int_stretcher.sv
// ============================================================================
// int_stretcher -- stretches the ULA frame interrupt to INT_TSTATES CPU T-states
// Revision 1.0
// ============================================================================
`default_nettype none

module int_stretcher
  import cpu_clken_gen_pkg::*;
#(
  parameter int INT_TSTATES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_en,
  input  logic int_n_ula,
  output logic int_n
);

  localparam logic [5:0] LAST = 6'(INT_TSTATES - 1);

  int_st_t    state;
  logic [5:0] ic;
  logic       int_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ic       <= 6'd0;
      int_prev <= 1'b1;
      int_n    <= 1'b1;
    end else begin
      int_prev <= int_n_ula;
      case (state)
        IDLE: begin
          if (int_prev && !int_n_ula) begin
            state <= ASSERT;
            ic    <= 6'd0;
            int_n <= 1'b0;
          end
        end
        ASSERT: begin
          // Fresh falling edges are ignored here; only T-states end the pulse.
          if (cpu_en) begin
            if (ic == LAST) begin
              state <= IDLE;
              int_n <= 1'b1;
            end else begin
              ic <= ic + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_clken_gen.sv
// ============================================================================
// cpu_clken_gen -- Z80 T-state enable from 28 MHz with glitch-free speed switch
// Revision 1.0
// ============================================================================
`default_nettype none

module cpu_clken_gen
  import cpu_clken_gen_pkg::*;
#(
  parameter int INT_TSTATES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cpu_speed,
  input  logic       force_slow,
  input  logic       wait_n,
  input  logic       int_n_ula,
  output logic       cpu_en,
  output logic [1:0] eff_speed,
  output logic       turbo_active,
  output logic       int_n
);

  logic [2:0] ph;
  logic [1:0] req;
  logic       slot;

  always_comb begin
    req = force_slow ? SPD_3M5 : speed_code(cpu_speed);
  end

  always_comb begin
    slot = 1'b0;
    case (eff_speed)
      SPD_3M5: slot = (ph == 3'd0);
      SPD_7M:  slot = (ph[1:0] == 2'd0);
      SPD_14M: slot = !ph[0];
      default: slot = 1'b1;
    endcase
  end

  // Speed only changes at the end of the ph==7 cycle so every speed's
  // first slot lands on ph==0 and ULA timing stays aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph        <= 3'd0;
      eff_speed <= SPD_3M5;
      cpu_en    <= 1'b0;
    end else begin
      ph     <= ph + 3'd1;
      cpu_en <= slot & wait_n;
      if (ph == 3'd7) begin
        eff_speed <= req;
      end
    end
  end

  assign turbo_active = (eff_speed != SPD_3M5);

  int_stretcher #(
    .INT_TSTATES(INT_TSTATES)
  ) u_int_stretcher (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_en   (cpu_en),
    .int_n_ula(int_n_ula),
    .int_n    (int_n)
  );

endmodule

`default_nettype wire

// File: tb/tb_cpu_clken_gen.sv
// ============================================================================
// tb_cpu_clken_gen -- randomized and directed bench against a cycle-count model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cpu_clken_gen;

  localparam int INT_TSTATES = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cpu_speed = 4'd0;
  logic       force_slow = 1'b0;
  logic       wait_n = 1'b1;
  logic       int_n_ula = 1'b1;
  logic       cpu_en;
  logic [1:0] eff_speed;
  logic       turbo_active;
  logic       int_n;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute cycle count since reset, divisor arithmetic,
  // and a count of consumed enables for the interrupt pulse.
  int   m_cyc = 0;
  int   m_eff = 0;
  logic m_en = 1'b0;
  logic m_int_n = 1'b1;
  logic m_prev = 1'b1;
  logic m_busy = 1'b0;
  int   m_cnt = 0;

  cpu_clken_gen #(
    .INT_TSTATES(INT_TSTATES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_speed   (cpu_speed),
    .force_slow  (force_slow),
    .wait_n      (wait_n),
    .int_n_ula   (int_n_ula),
    .cpu_en      (cpu_en),
    .eff_speed   (eff_speed),
    .turbo_active(turbo_active),
    .int_n       (int_n)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic n_en;
    int   div;
    if (!rst_n) begin
      m_cyc   = 0;
      m_eff   = 0;
      m_en    = 1'b0;
      m_int_n = 1'b1;
      m_prev  = 1'b1;
      m_busy  = 1'b0;
      m_cnt   = 0;
    end else begin
      div  = 8 >> m_eff;
      n_en = ((m_cyc % div) == 0) && wait_n;
      if (m_busy) begin
        if (m_en) begin
          m_cnt++;
          if (m_cnt == INT_TSTATES) begin
            m_busy  = 1'b0;
            m_int_n = 1'b1;
          end
        end
      end else if (m_prev && !int_n_ula) begin
        m_busy  = 1'b1;
        m_cnt   = 0;
        m_int_n = 1'b0;
      end
      m_prev = int_n_ula;
      if ((m_cyc % 8) == 7) begin
        m_eff = force_slow ? 0 : ((cpu_speed >= 4'd3) ? 3 : int'(cpu_speed));
      end
      m_en = n_en;
      m_cyc++;
    end
  endtask

  function automatic logic [4:0] model_vec();
    return {m_en, 2'(m_eff), (m_eff != 0), m_int_n};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({cpu_en, eff_speed, turbo_active, int_n} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state got %b want 00001", {cpu_en, eff_speed, turbo_active, int_n});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (cpu_en !== ((m_cyc % 8) == 1)) begin
        errors++;
        $display("FAIL slow_en_align cyc %0d got %b want %b", m_cyc, cpu_en, ((m_cyc % 8) == 1));
      end
      checks++;
      if ({cpu_en, eff_speed, turbo_active, int_n} !== model_vec()) begin
        errors++;
        $display("FAIL slow_model cyc %0d got %b want %b", m_cyc, {cpu_en, eff_speed, turbo_active, int_n}, model_vec());
      end
    end
  endtask

  task automatic test_turbo();
    while ((m_cyc % 8) != 2) tick();
    cpu_speed = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (eff_speed !== 2'b00) begin
        errors++;
        $display("FAIL turbo_hold cyc %0d got %b want 00", m_cyc, eff_speed);
      end
    end
    tick();
    checks++;
    if ({eff_speed, turbo_active} !== 3'b111) begin
      errors++;
      $display("FAIL turbo_switch got %b want 111", {eff_speed, turbo_active});
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (cpu_en !== 1'b1) begin
        errors++;
        $display("FAIL turbo_every_cycle cyc %0d got %b want 1", m_cyc, cpu_en);
      end
    end
    cpu_speed = 4'd1;
    for (int i = 0; i < 16; i++) tick();
    cpu_speed = 4'd9;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({cpu_en, eff_speed, turbo_active, int_n} !== model_vec()) begin
        errors++;
        $display("FAIL code9_model cyc %0d got %b want %b", m_cyc, {cpu_en, eff_speed, turbo_active, int_n}, model_vec());
      end
    end
    checks++;
    if (eff_speed !== 2'b11) begin
      errors++;
      $display("FAIL code9_speed got %b want 11", eff_speed);
    end
  endtask

  task automatic test_force_slow();
    bit seen_slow = 1'b0;
    cpu_speed = 4'd2;
    for (int i = 0; i < 16; i++) tick();
    while ((m_cyc % 8) != 1) tick();
    force_slow = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    force_slow = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (eff_speed !== 2'b10) begin
        errors++;
        $display("FAIL force_short cyc %0d got %b want 10", m_cyc, eff_speed);
      end
    end
    force_slow = 1'b1;
    for (int i = 0; i < 44; i++) begin
      if (i == 20) force_slow = 1'b0;
      tick();
      if (eff_speed == 2'b00) seen_slow = 1'b1;
      checks++;
      if ({cpu_en, eff_speed, turbo_active, int_n} !== model_vec()) begin
        errors++;
        $display("FAIL force_long cyc %0d got %b want %b", m_cyc, {cpu_en, eff_speed, turbo_active, int_n}, model_vec());
      end
    end
    checks++;
    if (!seen_slow || eff_speed !== 2'b10) begin
      errors++;
      $display("FAIL force_restore seen_slow %0d got %b want 10", seen_slow, eff_speed);
    end
  endtask

  task automatic test_wait();
    int got_en = 0;
    int exp_en = 0;
    cpu_speed = 4'd1;
    for (int i = 0; i < 16; i++) tick();
    wait_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) wait_n = 1'b1;
      tick();
      got_en += int'(cpu_en);
      exp_en += int'(m_en);
    end
    checks++;
    if (got_en !== exp_en) begin
      errors++;
      $display("FAIL wait_count got %0d want %0d", got_en, exp_en);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (cpu_en !== ((m_cyc % 4) == 1)) begin
        errors++;
        $display("FAIL wait_phase cyc %0d got %b want %b", m_cyc, cpu_en, ((m_cyc % 4) == 1));
      end
    end
  endtask

  task automatic test_int_stretch();
    int low = 0;
    cpu_speed = 4'd3;
    for (int i = 0; i < 16; i++) tick();
    int_n_ula = 1'b0;
    for (int i = 0; i < 72; i++) begin
      if (i == 64) int_n_ula = 1'b1;
      tick();
      low += int'(!int_n);
    end
    checks++;
    if (low !== 32) begin
      errors++;
      $display("FAIL int_28m_width got %0d want 32", low);
    end
    low = 0;
    for (int i = 0; i < 54; i++) begin
      int_n_ula = !((i < 3) || (i >= 6 && i < 46));
      tick();
      low += int'(!int_n);
    end
    checks++;
    if (low !== 32) begin
      errors++;
      $display("FAIL int_refall_width got %0d want 32", low);
    end
    cpu_speed = 4'd0;
    for (int i = 0; i < 16; i++) tick();
    while ((m_cyc % 8) != 1) tick();
    int_n_ula = 1'b0;
    low = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      low += int'(!int_n);
      checks++;
      if ({cpu_en, eff_speed, turbo_active, int_n} !== model_vec()) begin
        errors++;
        $display("FAIL int_3m5_model cyc %0d got %b want %b", m_cyc, {cpu_en, eff_speed, turbo_active, int_n}, model_vec());
      end
    end
    int_n_ula = 1'b1;
    checks++;
    if (low !== 256) begin
      errors++;
      $display("FAIL int_3m5_width got %0d want 256", low);
    end
  endtask

  task automatic test_reset_mid();
    cpu_speed = 4'd2;
    for (int i = 0; i < 16; i++) tick();
    int_n_ula = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (int_n !== 1'b0) begin
      errors++;
      $display("FAIL int_before_reset got %b want 0", int_n);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({cpu_en, eff_speed, turbo_active, int_n} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_mid got %b want 00001", {cpu_en, eff_speed, turbo_active, int_n});
    end
    rst_n = 1'b1;
    int_n_ula = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) cpu_speed = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) force_slow = ~force_slow;
      wait_n = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) int_n_ula = ~int_n_ula;
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
      checks++;
      if ({cpu_en, eff_speed, turbo_active, int_n} !== model_vec()) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", m_cyc, {cpu_en, eff_speed, turbo_active, int_n}, model_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_turbo();
    test_force_slow();
    test_wait();
    test_int_stretch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
